tea_search_scheduler: RTL and testbench

- Sequences a key-space search through the 32-stage pipelined TEA decryptor.
- Issues one candidate key index per enabled cycle to the key decoder front end.
- Keeps a shadow tag pipeline that matches the decryptor latency, so each decrypted block is tied to the index that produced it.
- Compares each decrypted block against a masked expected plaintext header and reports the first (lowest) matching index. Sits between the host/register interface and the decoder + TEA pipeline.

---
 rtl/tea_search_scheduler.sv | 114 +++++++++++
 tb/tb_tea_search_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tea_search_scheduler.sv
// Key-space search sequencer for a pipelined TEA decryptor: issues candidate
// indices, tracks them through a latency-matched tag pipeline, reports the first hit.
module tea_search_scheduler #(
    parameter int          LAT    = 32,
    parameter int          IDX_W  = 30,
    parameter logic [63:0] EXPECT = 64'h255044462D312E35,
    parameter logic [63:0] MASK   = 64'hFFFFFFFFFFFFFF00
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    input  logic [63:0]      pt_in,
    output logic [IDX_W-1:0] cand_idx,
    output logic             cand_valid,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] found_idx,
    output logic [31:0]      tested_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;

    stateT            state;
    logic [IDX_W-1:0] curIdx;
    logic [IDX_W-1:0] lastIdx;
    logic [LAT-1:0]   tagValid;
    logic [IDX_W-1:0] tagIdx [LAT];
    logic             tagOutValid;
    logic             hit;

    assign tagOutValid = tagValid[LAT-1];
    assign hit         = tagOutValid && (((pt_in ^ EXPECT) & MASK) == 64'd0);

    // Outputs are decodes of the state register; only cand_valid follows ena.
    assign cand_idx   = curIdx;
    assign cand_valid = (state == ISSUE) && ena;
    assign busy       = (state == ISSUE) || (state == DRAIN);
    assign done       = (state == DONE);

    // Valids are cleared in DONE so leftovers from an early hit never reach IDLE.
    always_ff @(posedge clk) begin
        if (rst || state == DONE)
            tagValid <= '0;
        else
            tagValid <= {tagValid[LAT-2:0], cand_valid};
    end

    // NOTE: index storage has no reset; a slot is only trusted when its valid bit is set.
    always_ff @(posedge clk) begin
        tagIdx[0] <= cand_idx;
        for (int i = 1; i < LAT; i++)
            tagIdx[i] <= tagIdx[i-1];
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            curIdx     <= '0;
            lastIdx    <= '0;
            found      <= 1'b0;
            found_idx  <= '0;
            tested_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        curIdx     <= first_idx;
                        lastIdx    <= last_idx;
                        found      <= 1'b0;
                        found_idx  <= '0;
                        tested_cnt <= '0;
                        state      <= (first_idx > last_idx) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (tagOutValid)
                        tested_cnt <= tested_cnt + 32'd1;
                    if (hit) begin
                        found     <= 1'b1;
                        found_idx <= tagIdx[LAT-1];
                        state     <= DONE;
                    end else if (ena) begin
                        // Compare before incrementing so an all-ones last index never wraps.
                        if (curIdx == lastIdx)
                            state <= DRAIN;
                        else
                            curIdx <= curIdx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (tagOutValid)
                        tested_cnt <= tested_cnt + 32'd1;
                    if (hit) begin
                        found     <= 1'b1;
                        found_idx <= tagIdx[LAT-1];
                        state     <= DONE;
                    end else if (tagValid == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_search_scheduler.sv
// Scoreboard bench for tea_search_scheduler: a latency-LAT model stands in for
// the TEA pipeline; expected results are queued at start and checked on done.
module tb_tea_search_scheduler;

    localparam int          LAT    = 32;
    localparam int          IDX_W  = 30;
    localparam logic [63:0] EXPECT = 64'h255044462D312E35;
    localparam logic [63:0] MISS   = EXPECT ^ 64'h0000_0100_0000_0000;

    typedef struct {
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [31:0]      tested;
        int               startCyc;
        int               lat;
    } expT;

    logic             clk = 1'b0;
    logic             rst, ena, start;
    logic [IDX_W-1:0] first_idx, last_idx;
    logic [63:0]      pt_in;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_valid, busy, done, found;
    logic [IDX_W-1:0] found_idx;
    logic [31:0]      tested_cnt;

    int passCnt  = 0;
    int totalCnt = 0;
    int cyc      = 0;
    int badEna   = 0;

    expT              sb[$];
    logic [IDX_W-1:0] issuedQ[$];
    logic [IDX_W-1:0] matchIdx[$];
    logic [63:0]      matchPt[$];
    logic [63:0]      ptPipe [LAT];

    tea_search_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .first_idx  (first_idx),
        .last_idx   (last_idx),
        .pt_in      (pt_in),
        .cand_idx   (cand_idx),
        .cand_valid (cand_valid),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .found_idx  (found_idx),
        .tested_cnt (tested_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Idle slots carry EXPECT so a design ignoring tag valids would falsely hit.
    function automatic logic [63:0] ptFor(input logic v, input logic [IDX_W-1:0] idx);
        if (v !== 1'b1) return EXPECT;
        for (int i = 0; i < matchIdx.size(); i++)
            if (matchIdx[i] == idx) return matchPt[i];
        return MISS;
    endfunction

    initial for (int i = 0; i < LAT; i++) ptPipe[i] = EXPECT;

    always @(posedge clk) begin
        ptPipe[0] <= ptFor(cand_valid, cand_idx);
        for (int i = 1; i < LAT; i++) ptPipe[i] <= ptPipe[i-1];
    end
    assign pt_in = ptPipe[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        expT e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                totalCnt++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                e = sb.pop_front();
                check("found", {63'd0, found}, {63'd0, e.found});
                check("found_idx", {34'd0, found_idx}, {34'd0, e.idx});
                check("tested_cnt", {32'd0, tested_cnt}, {32'd0, e.tested});
                if (e.lat >= 0)
                    check("done_latency", 64'(cyc - e.startCyc), 64'(e.lat));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && cand_valid === 1'b1) begin
            issuedQ.push_back(cand_idx);
            if (ena !== 1'b1) badEna++;
        end
    end

    task automatic startSearch(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l,
                               input logic expFound, input logic [IDX_W-1:0] expIdx,
                               input logic [31:0] expTested, input int expLat);
        expT e;
        @(posedge clk); #1;
        issuedQ.delete();
        first_idx = f;
        last_idx  = l;
        start     = 1'b1;
        e.found = expFound; e.idx = expIdx; e.tested = expTested;
        e.startCyc = cyc + 1; e.lat = expLat;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input bit toggle);
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
            else begin
                n++;
                @(posedge clk); #1;
                if (toggle) ena = ~ena;
            end
        end
        ena = 1'b1;
        if (!seen) begin
            totalCnt++;
            $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse", budget);
        end else begin
            @(posedge clk); #1;
            @(negedge clk);
            check("done_one_cycle", {63'd0, done}, 64'd0);
        end
    endtask

    task automatic checkIssued(input logic [IDX_W-1:0] f, input int n);
        check("issued_count", 64'(issuedQ.size()), 64'(n));
        for (int i = 0; i < n && i < issuedQ.size(); i++)
            check("issued_idx", {34'd0, issuedQ[i]}, {34'd0, f + IDX_W'(i)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; start = 1'b0; first_idx = '0; last_idx = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_cand_valid", {63'd0, cand_valid}, 64'd0);
        check("rst_cand_idx", {34'd0, cand_idx}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_found", {63'd0, found}, 64'd0);
        check("rst_tested", {32'd0, tested_cnt}, 64'd0);

        // Range 0..9, hit on 7: issued at offset 7 -> done 1+7+LAT after start.
        matchIdx = '{30'd7}; matchPt = '{EXPECT};
        startSearch(30'd0, 30'd9, 1'b1, 30'd7, 32'd8, 40);
        waitDone(200, 1'b0);

        // Range 100..103, no match: done N+LAT+1 = 37 cycles after start.
        matchIdx.delete(); matchPt.delete();
        startSearch(30'd100, 30'd103, 1'b0, 30'd0, 32'd4, 37);
        waitDone(200, 1'b0);
        checkIssued(30'd100, 4);

        // Range 0..5 with ena alternating.
        startSearch(30'd0, 30'd5, 1'b0, 30'd0, 32'd6, -1);
        waitDone(200, 1'b1);
        checkIssued(30'd0, 6);
        check("valid_only_with_ena", 64'(badEna), 64'd0);

        // Single all-ones index that matches.
        matchIdx = '{30'h3FFFFFFF}; matchPt = '{EXPECT};
        startSearch(30'h3FFFFFFF, 30'h3FFFFFFF, 1'b1, 30'h3FFFFFFF, 32'd1, 33);
        waitDone(200, 1'b0);
        checkIssued(30'h3FFFFFFF, 1);

        // Empty range: DONE straight from the start edge.
        startSearch(30'd5, 30'd4, 1'b0, 30'd0, 32'd0, 0);
        waitDone(10, 1'b0);

        // Hits on 3 (low byte differs, masked) and 4; start while busy is ignored.
        matchIdx = '{30'd3, 30'd4}; matchPt = '{EXPECT ^ 64'hA5, EXPECT};
        startSearch(30'd0, 30'd9, 1'b1, 30'd3, 32'd4, 36);
        @(posedge clk); #1;
        first_idx = 30'd50; last_idx = 30'd60; start = 1'b1;
        @(negedge clk);
        check("busy_during_issue", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(200, 1'b0);

        // New start clears found; reset mid-ISSUE aborts with no done.
        matchIdx.delete(); matchPt.delete();
        startSearch(30'd0, 30'd20, 1'b0, 30'd0, 32'd21, -1);
        @(negedge clk);
        check("restart_clears_found", {63'd0, found}, 64'd0);
        check("restart_clears_tested", {32'd0, tested_cnt}, 64'd0);
        check("restart_busy", {63'd0, busy}, 64'd1);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_cand_valid", {63'd0, cand_valid}, 64'd0);
        check("midrst_cand_idx", {34'd0, cand_idx}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_found", {63'd0, found}, 64'd0);
        check("midrst_tested", {32'd0, tested_cnt}, 64'd0);
        repeat (LAT + 5) @(posedge clk);

        // Normal search after reset, hit on 201 at offset 1.
        matchIdx = '{30'd201}; matchPt = '{EXPECT};
        startSearch(30'd200, 30'd202, 1'b1, 30'd201, 32'd2, 34);
        waitDone(200, 1'b0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
